// File: rtl/instruction_fetch_controller.sv
// instruction_fetch_controller: sequences opcode + immediate byte fetches into the IR.
// Optional FETCH_TIMEOUT_EN adds a no-ack watchdog and an ERR state.
module instruction_fetch_controller #(
   parameter int ADDR_W         = 16,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              fetch_start,
   input  logic [ADDR_W-1:0] pc,
   input  logic              flush,
   input  logic              mem_ack,
   input  logic [7:0]        opcode,
   input  logic              instr_consume,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              ir_clear,
   output logic              ir_hold,
   output logic              instr_valid,
   output logic [1:0]        instr_len,
   output logic [ADDR_W-1:0] pc_next,
   output logic              busy,
   output logic              fetch_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_REQ_OP,
      S_DECODE,
      S_REQ_LO,
      S_REQ_HI,
      S_DONE
`ifdef FETCH_TIMEOUT_EN
      ,
      S_ERR
`endif
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_base;
   logic [1:0]          r_off;
   logic [1:0]          r_len;
   logic                r_mem_req;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic                r_ir_clear;
   logic                r_ir_hold;
   logic                r_instr_valid;
   logic [1:0]          r_instr_len;
   logic [ADDR_W-1:0]   r_pc_next;
   logic                r_busy;

   state_t              w_nxt;
   logic [ADDR_W-1:0]   w_base;
   logic [1:0]          w_off;
   logic [1:0]          w_len;
   logic [1:0]          w_dec_len;
   logic                w_req_cur;
   logic                w_req_nxt;

`ifdef FETCH_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]       r_tmo;
   logic [TW-1:0]       w_tmo;
   logic                r_fetch_err;
   logic                w_tmo_hit;
   assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
`endif

   // Opcode class in the top two bits selects 1, 2 or 3 bytes
   assign w_dec_len = (opcode[7:6] == 2'b00) ? 2'd1 :
                      (opcode[7:6] == 2'b01) ? 2'd2 : 2'd3;

   assign w_req_cur = (r_state == S_REQ_OP) ||
                      (r_state == S_REQ_LO) ||
                      (r_state == S_REQ_HI);

   assign w_req_nxt = (w_nxt == S_REQ_OP) ||
                      (w_nxt == S_REQ_LO) ||
                      (w_nxt == S_REQ_HI);

   always_comb begin
      w_nxt  = r_state;
      w_base = r_base;
      w_off  = r_off;
      w_len  = r_len;
      if (flush) begin
         w_nxt = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (fetch_start) begin
                  w_nxt  = S_CLEAR;
                  w_base = pc;
                  w_off  = 2'd0;
               end
            end
            S_CLEAR: w_nxt = S_REQ_OP;
            S_REQ_OP, S_REQ_LO, S_REQ_HI: begin
               if (mem_ack) begin
                  w_off = r_off + 2'd1;
                  if (r_state == S_REQ_OP)
                     w_nxt = S_DECODE;
                  else if (r_state == S_REQ_LO && r_len == 2'd3)
                     w_nxt = S_REQ_HI;
                  else
                     w_nxt = S_DONE;
               end
`ifdef FETCH_TIMEOUT_EN
               else if (w_tmo_hit) begin
                  w_nxt = S_ERR;
               end
`endif
            end
            S_DECODE: begin
               w_len = w_dec_len;
               w_nxt = (w_dec_len == 2'd1) ? S_DONE : S_REQ_LO;
            end
            S_DONE: begin
               if (instr_consume)
                  w_nxt = S_IDLE;
            end
`ifdef FETCH_TIMEOUT_EN
            S_ERR: begin
               if (fetch_start) begin
                  w_nxt  = S_CLEAR;
                  w_base = pc;
                  w_off  = 2'd0;
               end
            end
`endif
            default: w_nxt = S_IDLE;
         endcase
      end
   end

`ifdef FETCH_TIMEOUT_EN
   always_comb begin
      w_tmo = '0;
      if (!flush && w_req_cur && w_req_nxt && !mem_ack)
         w_tmo = r_tmo + 1'b1;
   end
`endif

   // Outputs are registered from the next-state decode
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state       <= S_IDLE;
         r_base        <= '0;
         r_off         <= 2'd0;
         r_len         <= 2'd0;
         r_mem_req     <= 1'b0;
         r_mem_addr    <= '0;
         r_ir_clear    <= 1'b0;
         r_ir_hold     <= 1'b1;
         r_instr_valid <= 1'b0;
         r_instr_len   <= 2'd0;
         r_pc_next     <= '0;
         r_busy        <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         r_tmo         <= '0;
         r_fetch_err   <= 1'b0;
`endif
      end else begin
         r_state       <= w_nxt;
         r_base        <= w_base;
         r_off         <= w_off;
         r_len         <= w_len;
         r_mem_req     <= w_req_nxt;
         r_mem_addr    <= w_base + ADDR_W'(w_off);
         r_ir_clear    <= (w_nxt == S_CLEAR);
         r_ir_hold     <= !w_req_nxt;
         r_instr_valid <= (w_nxt == S_DONE);
         r_busy        <= (w_nxt != S_IDLE);
         if (w_nxt == S_DONE) begin
            r_instr_len <= w_len;
            r_pc_next   <= w_base + ADDR_W'(w_len);
         end
`ifdef FETCH_TIMEOUT_EN
         r_tmo         <= w_tmo;
         r_fetch_err   <= (w_nxt == S_ERR);
`endif
      end
   end

   assign mem_req     = r_mem_req;
   assign mem_addr    = r_mem_addr;
   assign ir_clear    = r_ir_clear;
   assign ir_hold     = r_ir_hold;
   assign instr_valid = r_instr_valid;
   assign instr_len   = r_instr_len;
   assign pc_next     = r_pc_next;
   assign busy        = r_busy;
`ifdef FETCH_TIMEOUT_EN
   assign fetch_err   = r_fetch_err;
`else
   assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Bench for instruction_fetch_controller: IR + memory model, transaction-level
// reference model compared every cycle, directed literal checks, random phase.
module tb_instruction_fetch_controller;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        fetch_start = 1'b0;
   logic [15:0] pc = '0;
   logic        flush = 1'b0;
   logic        mem_ack = 1'b0;
   logic [7:0]  opcode;
   logic        instr_consume = 1'b0;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        ir_clear;
   logic        ir_hold;
   logic        instr_valid;
   logic [1:0]  instr_len;
   logic [15:0] pc_next;
   logic        busy;
   logic        fetch_err;

   instruction_fetch_controller #(.ADDR_W(16), .TIMEOUT_CYCLES(15)) dut (
      .clk(clk), .nrst(nrst), .fetch_start(fetch_start), .pc(pc),
      .flush(flush), .mem_ack(mem_ack), .opcode(opcode),
      .instr_consume(instr_consume), .mem_req(mem_req),
      .mem_addr(mem_addr), .ir_clear(ir_clear), .ir_hold(ir_hold),
      .instr_valid(instr_valid), .instr_len(instr_len),
      .pc_next(pc_next), .busy(busy), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Memory and instruction register the controller steers
   logic [7:0]  mem [0:65535];
   logic [23:0] r_ir = '0;
   logic [1:0]  r_irc = '0;
   assign opcode = r_ir[23:16];

   always @(posedge clk) begin
      if (ir_clear) begin
         r_ir  <= '0;
         r_irc <= '0;
      end else if (!ir_hold && mem_ack) begin
         case (r_irc)
            2'd0:    r_ir[23:16] <= mem[mem_addr];
            2'd1:    r_ir[15:8]  <= mem[mem_addr];
            default: r_ir[7:0]   <= mem[mem_addr];
         endcase
         if (r_irc != 2'd3) r_irc <= r_irc + 2'd1;
      end
   end

   // Reference model: activity mode plus bytes fetched / bytes needed
   localparam int MI = 0, MC = 1, MF = 2, MD = 3, MO = 4, ME = 5;
   int          m_mode = MI;
   logic [15:0] m_base = '0;
   int          m_got = 0;
   int          m_need = 0;
   int          m_tmo = 0;
   int          m_len = 0;
   logic [15:0] m_pcn = '0;

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         m_mode = MI; m_base = '0; m_got = 0; m_need = 0;
         m_tmo = 0; m_len = 0; m_pcn = '0;
      end else if (flush) begin
         m_mode = MI;
      end else begin
         case (m_mode)
            MI, ME: if (fetch_start) begin
               m_base = pc; m_got = 0; m_mode = MC;
            end
            MC: begin m_mode = MF; m_tmo = 0; end
            MF: begin
               if (mem_ack) begin
                  m_got++;
                  m_tmo = 0;
                  if (m_got == 1) m_mode = MD;
                  else if (m_got == m_need) begin
                     m_mode = MO; m_len = m_need;
                     m_pcn = 16'(m_base + 16'(m_need));
                  end
               end else begin
                  m_tmo++;
`ifdef FETCH_TIMEOUT_EN
                  if (m_tmo == 15) m_mode = ME;
`endif
               end
            end
            MD: begin
               m_need = (opcode[7:6] == 2'b00) ? 1 :
                        (opcode[7:6] == 2'b01) ? 2 : 3;
               m_tmo = 0;
               if (m_need == 1) begin
                  m_mode = MO; m_len = 1;
                  m_pcn = 16'(m_base + 16'd1);
               end else m_mode = MF;
            end
            MO: if (instr_consume) m_mode = MI;
            default: m_mode = MI;
         endcase
      end
      #1;
      chk("mem_req", 32'(mem_req), 32'(m_mode == MF));
      if (m_mode == MF || !nrst)
         chk("mem_addr", 32'(mem_addr), 32'(16'(m_base + 16'(m_got))));
      chk("ir_clear", 32'(ir_clear), 32'(m_mode == MC));
      chk("ir_hold", 32'(ir_hold), 32'(m_mode != MF));
      chk("instr_valid", 32'(instr_valid), 32'(m_mode == MO));
      chk("busy", 32'(busy), 32'(m_mode != MI));
      chk("fetch_err", 32'(fetch_err), 32'(m_mode == ME));
      if (m_mode == MO || !nrst) begin
         chk("instr_len", 32'(instr_len), 32'(m_len));
         chk("pc_next", 32'(pc_next), 32'(m_pcn));
      end
   end

   logic [15:0] q_addr [$];
   int          lat;

   // Fetch with a fixed ack delay per byte; lat = cycles from start edge
   task automatic do_fetch(input logic [15:0] a, input int dly);
      int w;
      w = 0;
      q_addr.delete();
      @(negedge clk);
      fetch_start = 1'b1; pc = a;
      @(negedge clk);
      fetch_start = 1'b0;
      lat = 1;
      while (!instr_valid && lat < 60) begin
         mem_ack = 1'b0;
         if (mem_req) begin
            if (w == dly) begin
               mem_ack = 1'b1; q_addr.push_back(mem_addr); w = 0;
            end else w++;
         end
         @(negedge clk);
         lat++;
      end
      mem_ack = 1'b0;
      if (lat >= 60) chk("fetch_bound", 32'(lat), 32'd0);
   endtask

   task automatic consume();
      instr_consume = 1'b1;
      @(negedge clk);
      instr_consume = 1'b0;
      chk("consume_idle", 32'(busy), 32'd0);
   endtask

   logic [23:0] ir_save;
   int          nreq;

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      mem[16'h0100] = 8'h12;
      mem[16'h0200] = 8'h45;
      mem[16'hFFFE] = 8'h80;
      mem[16'h0300] = 8'h45;
      repeat (2) @(negedge clk);
      chk("rst_hold", 32'(ir_hold), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      nrst = 1'b1;
      @(negedge clk);

      do_fetch(16'h0100, 0);
      chk("t1_lat", 32'(lat), 32'd4);
      chk("t1_nreq", 32'(q_addr.size()), 32'd1);
      chk("t1_addr", 32'(q_addr[0]), 32'h0100);
      chk("t1_len", 32'(instr_len), 32'd1);
      chk("t1_pcn", 32'(pc_next), 32'h0101);
      consume();

      do_fetch(16'h0200, 3);
      chk("t2_lat", 32'(lat), 32'd11);
      chk("t2_nreq", 32'(q_addr.size()), 32'd2);
      chk("t2_a0", 32'(q_addr[0]), 32'h0200);
      chk("t2_a1", 32'(q_addr[1]), 32'h0201);
      chk("t2_len", 32'(instr_len), 32'd2);
      chk("t2_pcn", 32'(pc_next), 32'h0202);
      consume();

      do_fetch(16'hFFFE, 0);
      chk("t3_lat", 32'(lat), 32'd6);
      chk("t3_nreq", 32'(q_addr.size()), 32'd3);
      chk("t3_a0", 32'(q_addr[0]), 32'hFFFE);
      chk("t3_a1", 32'(q_addr[1]), 32'hFFFF);
      chk("t3_a2", 32'(q_addr[2]), 32'h0000);
      chk("t3_len", 32'(instr_len), 32'd3);
      chk("t3_pcn", 32'(pc_next), 32'h0001);
      consume();

      // Flush while the low immediate byte is outstanding
      @(negedge clk);
      fetch_start = 1'b1; pc = 16'h0300;
      @(negedge clk);
      fetch_start = 1'b0;
      @(negedge clk);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      @(negedge clk);
      chk("t4_req", 32'(mem_req), 32'd1);
      chk("t4_addr", 32'(mem_addr), 32'h0301);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("t4_req_off", 32'(mem_req), 32'd0);
      chk("t4_busy", 32'(busy), 32'd0);
      chk("t4_hold", 32'(ir_hold), 32'd1);
      ir_save = r_ir;
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("t4_ir", 32'(r_ir), 32'(ir_save));

      // DONE holds against fetch_start until consumed
      do_fetch(16'h0100, 0);
      for (int i = 0; i < 5; i++) begin
         fetch_start = (i == 2); pc = 16'h0400;
         @(negedge clk);
         chk("t5_valid", 32'(instr_valid), 32'd1);
         chk("t5_req", 32'(mem_req), 32'd0);
      end
      fetch_start = 1'b0;
      consume();
      chk("t5_valid_off", 32'(instr_valid), 32'd0);

`ifdef FETCH_TIMEOUT_EN
      @(negedge clk);
      fetch_start = 1'b1; pc = 16'h0500;
      @(negedge clk);
      fetch_start = 1'b0;
      nreq = 0;
      for (int i = 0; i < 30 && !fetch_err; i++) begin
         @(negedge clk);
         if (mem_req) nreq++;
      end
      chk("t6_err", 32'(fetch_err), 32'd1);
      chk("t6_nreq", 32'(nreq), 32'd15);
      chk("t6_req", 32'(mem_req), 32'd0);
      fetch_start = 1'b1; pc = 16'h0100;
      @(negedge clk);
      fetch_start = 1'b0;
      chk("t6_clear", 32'(ir_clear), 32'd1);
      chk("t6_err_off", 32'(fetch_err), 32'd0);
`endif

      // Asynchronous reset while a request is outstanding
      fetch_start = 1'b1; pc = 16'h0600;
      @(negedge clk);
      fetch_start = 1'b0;
      for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
      chk("t7_inreq", 32'(mem_req), 32'd1);
      nrst = 1'b0;
      #1;
      chk("t7_req", 32'(mem_req), 32'd0);
      chk("t7_addr", 32'(mem_addr), 32'd0);
      chk("t7_hold", 32'(ir_hold), 32'd1);
      chk("t7_busy", 32'(busy), 32'd0);
      chk("t7_err", 32'(fetch_err), 32'd0);
      @(negedge clk);
      nrst = 1'b1;

      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         flush         = ($urandom_range(0, 99) < 3);
         fetch_start   = ($urandom_range(0, 99) < 25);
         pc            = ($urandom_range(0, 4) == 0) ?
                         16'(16'hFFFF - 16'($urandom_range(0, 2))) :
                         16'($urandom);
         mem_ack       = ($urandom_range(0, 99) < 50);
         instr_consume = ($urandom_range(0, 99) < 40);
         nrst          = ($urandom_range(0, 999) >= 3);
      end
      @(negedge clk);
      flush = 1'b0; fetch_start = 1'b0; mem_ack = 1'b0;
      instr_consume = 1'b0; nrst = 1'b1;
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
